mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 256x32 data memory between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Requesters use valid/ready handshakes; arbitration is round-robin. Read data returns one cycle after grant.
- Also contains a clear sequencer that zeroes the whole memory on request, one word per cycle.
- Sits between the core and the memory; the memory's own rst input is tied low and unused.

Parameters:
- DEPTH, 256, number of memory words swept by a clear; counter width is $clog2(DEPTH).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- p0_valid  in  1  port 0 request valid.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 word address.
- p0_wdata  in  DW  port 0 write data.
- p0_ready  out  1  port 0 granted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DW  port 0 read data.
- p1_valid, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata  same as port 0, for port 1.
- clr_start  in  1  request a memory clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse on the last clear write.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory data_in.
- mem_rd_en  out  1  to memory rd_en.
- mem_wr_en  out  1  to memory wr_en.
- mem_rdata  in  DW  from memory data_out (combinational read).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, clr_cnt=0, last_grant=1 (so port 0 wins first contention).
  - p0/p1_rvalid=0, p0/p1_rdata=0, clr_done=0.
  - clr_busy=0, all ready outputs 0, mem_rd_en=0, mem_wr_en=0.
- State machine has two states: IDLE and CLEAR.
- IDLE with clr_start=1:
  - No grant this cycle; both ready=0; mem enables 0.
  - Next state is CLEAR with clr_cnt=0.
- IDLE with clr_start=0, arbitration is combinational:
  - Only one port valid: that port wins.
  - Both valid: the port other than last_grant wins.
  - Winner's ready=1 and the loser's ready=0 in the same cycle; last_grant updates to the winner at posedge.
- Memory drive while a port is granted:
  - mem_addr = winner addr.
  - mem_wr_en = winner we; mem_wdata = winner wdata.
  - mem_rd_en = !we.
- Memory drive with no grant:
  - mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Read response:
  - A read granted in cycle T sets that port's rvalid=1 for exactly cycle T+1; rdata holds mem_rdata sampled at the end of T.
  - rdata holds its value until the next read on that port.
  - There is no response backpressure.
- Writes produce no response. The write completes at the posedge ending the grant cycle.
- Back-to-back requests: a port may be granted in consecutive cycles. Throughput is 1 request/cycle total.
- Requesters hold valid, addr, we and wdata stable until ready. A dropped valid before ready is legal; nothing is issued for it.
- CLEAR state:
  - Each cycle: mem_wr_en=1, mem_rd_en=0, mem_wdata=0, mem_addr=zero-extended clr_cnt.
  - clr_cnt increments each cycle; clr_busy=1; both ready=0.
  - When clr_cnt==DEPTH-1: clr_done=1 for that cycle, then next state is IDLE and clr_cnt returns to 0.
  - Total duration is DEPTH cycles.
  - clr_start is ignored during CLEAR.
  - Pending requests stall with valid held and are arbitrated normally in the first IDLE cycle.
- Reset mid-clear: returns immediately to IDLE. The memory is left partially cleared; there is no restart.
- Reset one cycle after a read grant: rvalid is forced 0 and the response is lost.

Test Plan:
- Reset, then p0 read at addr 5 holding 0xDEADBEEF → p0_ready=1 in cycle T; p0_rvalid=1 and p0_rdata=0xDEADBEEF in T+1; p1_rvalid stays 0.
- p0 and p1 both valid for 4 cycles (p0 read addr 1, p1 read addr 2) → grants alternate p0,p1,p0,p1; each rvalid pulses one cycle after its own grant.
- p1 write 0x12345678 to addr 10, then p0 read addr 10 next cycle → p0_rdata=0x12345678.
- clr_start pulse with p1_valid held → clr_busy high for 256 cycles; mem_addr sweeps 0..255 with wr_en=1; clr_done on addr 255; p1_ready first asserts in the following cycle; later reads of addr 10 return 0.
- Assert rst=0 at clr_cnt=100 → clr_busy drops asynchronously; after release, addr 150 retains its old value and addr 50 reads 0.
- clr_start asserted again during CLEAR → no restart; duration stays exactly 256 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between instruction
// fetch (port 0) and load/store (port 1), with a sequencer that zeroes the memory.
module mem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_valid,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] clr_cnt;
  logic          last_grant;
  logic          arb_en;
  logic          grant0;
  logic          grant1;

  // Grants are gated by rst so ready and memory enables stay low while reset is held.
  always_comb begin
    arb_en   = rst && (state == IDLE) && !clr_start;
    grant0   = arb_en && p0_valid && (!p1_valid || last_grant);
    grant1   = arb_en && p1_valid && (!p0_valid || !last_grant);
    p0_ready = grant0;
    p1_ready = grant1;
    clr_busy = (state == CLEAR);
    clr_done = (state == CLEAR) && (clr_cnt == CNT_LAST);
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    if (state == CLEAR) begin
      mem_addr  = AW'(clr_cnt);
      mem_wr_en = 1'b1;
    end else if (grant0) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wr_en = p0_we;
      mem_rd_en = !p0_we;
    end else if (grant1) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wr_en = p1_we;
      mem_rd_en = !p1_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      last_grant <= 1'b1;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      p0_rvalid <= grant0 && !p0_we;
      p1_rvalid <= grant1 && !p1_we;
      if (grant0 && !p0_we) p0_rdata <= mem_rdata;
      if (grant1 && !p1_we) p1_rdata <= mem_rdata;

      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;

      if (state == IDLE) begin
        clr_cnt <= '0;
        if (clr_start) state <= CLEAR;
      end else if (clr_cnt == CNT_LAST) begin
        state   <= IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// round-robin / memory reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_valid, p0_we, p1_valid, p1_we, clr_start;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ready, p0_rvalid, p1_ready, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        clr_busy, clr_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) if (mem_wr_en && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;

  mem_arbiter #(.DEPTH(256), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    clr_start = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    p0_valid = 1; p1_valid = 1;
    @(negedge clk);
    n_cmp++; if (p0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_p0_ready got=%0b want=0", p0_ready); end
    n_cmp++; if (p1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_p1_ready got=%0b want=0", p1_ready); end
    n_cmp++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%0b%0b want=00", p0_rvalid, p1_rvalid); end
    n_cmp++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h/%h want=0", p0_rdata, p1_rdata); end
    n_cmp++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_clr got busy=%0b done=%0b want=0", clr_busy, clr_done); end
    n_cmp++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en got rd=%0b wr=%0b want=0", mem_rd_en, mem_wr_en); end
    tick();
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_single_read();
    p0_valid = 1; p0_we = 0; p0_addr = 5;
    @(negedge clk);
    n_cmp++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready got=%0b%0b want=10", p0_ready, p1_ready); end
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'd5) begin n_bad++; $display("FAIL single_mem got rd=%0b wr=%0b addr=%0d want 1 0 5", mem_rd_en, mem_wr_en, mem_addr); end
    tick();
    p0_valid = 0;
    @(negedge clk);
    n_cmp++; if (p0_rvalid !== 1'b1) begin n_bad++; $display("FAIL single_rvalid got=%0b want=1", p0_rvalid); end
    n_cmp++; if (p0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rdata got=%h want=deadbeef", p0_rdata); end
    n_cmp++; if (p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL single_p1_rvalid got=%0b want=0", p1_rvalid); end
    tick();
    @(negedge clk);
    n_cmp++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_hold got rv=%0b rd=%h want 0 deadbeef", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_contention();
    int prev;
    apply_reset();
    p0_valid = 1; p0_we = 0; p0_addr = 1;
    p1_valid = 1; p1_we = 0; p1_addr = 2;
    prev = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (p0_ready !== (c % 2 == 0) || p1_ready !== (c % 2 == 1)) begin n_bad++; $display("FAIL rr_ready c=%0d got=%0b%0b want p%0d", c, p0_ready, p1_ready, c % 2); end
      n_cmp++; if (mem_addr !== ((c % 2 == 0) ? 32'd1 : 32'd2)) begin n_bad++; $display("FAIL rr_addr c=%0d got=%0d", c, mem_addr); end
      if (prev >= 0) begin
        n_cmp++; if (p0_rvalid !== (prev == 0) || p1_rvalid !== (prev == 1)) begin n_bad++; $display("FAIL rr_rvalid c=%0d got=%0b%0b want from p%0d", c, p0_rvalid, p1_rvalid, prev); end
      end
      prev = c % 2;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rr_last_rvalid got=%0b%0b want=01", p0_rvalid, p1_rvalid); end
    n_cmp++; if (p0_rdata !== ref_mem[1] || p1_rdata !== ref_mem[2]) begin n_bad++; $display("FAIL rr_rdata got=%h/%h want=%h/%h", p0_rdata, p1_rdata, ref_mem[1], ref_mem[2]); end
    tick();
  endtask

  task automatic test_write_read();
    p1_valid = 1; p1_we = 1; p1_addr = 10; p1_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++; if (p1_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL wr_grant got rdy=%0b wr=%0b rd=%0b want 1 1 0", p1_ready, mem_wr_en, mem_rd_en); end
    n_cmp++; if (mem_addr !== 32'd10 || mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL wr_bus got addr=%0d data=%h", mem_addr, mem_wdata); end
    ref_mem[10] = 32'h12345678;
    tick();
    idle_inputs();
    p0_valid = 1; p0_we = 0; p0_addr = 10;
    @(negedge clk);
    n_cmp++; if (p0_ready !== 1'b1 || p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_then_rd got p0_ready=%0b p1_rvalid=%0b want 1 0", p0_ready, p1_rvalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678) begin n_bad++; $display("FAIL wr_readback got rv=%0b rd=%h want 1 12345678", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_clear();
    p1_valid = 1; p1_we = 0; p1_addr = 10;
    clr_start = 1;
    @(negedge clk);
    n_cmp++; if (p1_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL clr_start_cycle got rdy=%0b wr=%0b rd=%0b want 000", p1_ready, mem_wr_en, mem_rd_en); end
    tick();
    clr_start = 0;
    for (int i = 0; i < 256; i++) begin
      clr_start = (i == 40);
      @(negedge clk);
      n_cmp++; if (clr_busy !== 1'b1 || p1_ready !== 1'b0) begin n_bad++; $display("FAIL clr_busy i=%0d got busy=%0b rdy=%0b want 1 0", i, clr_busy, p1_ready); end
      n_cmp++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL clr_drive i=%0d got wr=%0b rd=%0b data=%h", i, mem_wr_en, mem_rd_en, mem_wdata); end
      n_cmp++; if (mem_addr !== 32'(i)) begin n_bad++; $display("FAIL clr_addr got=%0d want=%0d", mem_addr, i); end
      n_cmp++; if (clr_done !== (i == 255)) begin n_bad++; $display("FAIL clr_done i=%0d got=%0b", i, clr_done); end
      tick();
    end
    clr_start = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    @(negedge clk);
    n_cmp++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin n_bad++; $display("FAIL clr_end got busy=%0b done=%0b want 0 0", clr_busy, clr_done); end
    n_cmp++; if (p1_ready !== 1'b1 || mem_addr !== 32'd10) begin n_bad++; $display("FAIL clr_stalled_grant got rdy=%0b addr=%0d want 1 10", p1_ready, mem_addr); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (p1_rvalid !== 1'b1 || p1_rdata !== ref_mem[10]) begin n_bad++; $display("FAIL clr_readback got rv=%0b rd=%h want 1 %h", p1_rvalid, p1_rdata, ref_mem[10]); end
    tick();
  endtask

  task automatic port0_write(input logic [31:0] a, input logic [31:0] d);
    p0_valid = 1; p0_we = 1; p0_addr = a; p0_wdata = d;
    tick();
    idle_inputs();
    ref_mem[a[7:0]] = d;
  endtask

  task automatic test_reset_mid_clear();
    port0_write(150, 32'hA5A50150);
    port0_write(50, 32'h5A5A0050);
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int i = 0; i < 100; i++) tick();
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'd100 || clr_busy !== 1'b1) begin n_bad++; $display("FAIL midclr_pos got addr=%0d busy=%0b want 100 1", mem_addr, clr_busy); end
    rst = 0;
    #1;
    n_cmp++; if (clr_busy !== 1'b0 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL midclr_async got busy=%0b wr=%0b want 0 0", clr_busy, mem_wr_en); end
    for (int i = 0; i < 100; i++) ref_mem[i] = 32'h0;
    tick();
    rst = 1;
    p0_valid = 1; p0_we = 0; p0_addr = 150;
    tick();
    p0_addr = 50;
    @(negedge clk);
    n_cmp++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hA5A50150) begin n_bad++; $display("FAIL midclr_kept got rv=%0b rd=%h want 1 a5a50150", p0_rvalid, p0_rdata); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0) begin n_bad++; $display("FAIL midclr_cleared got rv=%0b rd=%h want 1 0", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_reset_after_read();
    p1_valid = 1; p1_we = 0; p1_addr = 7;
    @(negedge clk);
    n_cmp++; if (p1_ready !== 1'b1) begin n_bad++; $display("FAIL rstrd_grant got=%0b want=1", p1_ready); end
    tick();
    idle_inputs();
    rst = 0;
    #1;
    n_cmp++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin n_bad++; $display("FAIL rstrd_lost got rv=%0b rd=%h want 0 0", p1_rvalid, p1_rdata); end
    tick();
    rst = 1;
  endtask

  task automatic test_random();
    logic        pv [2];
    logic        pwe[2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic        exp_rv[2];
    logic [31:0] exp_rd[2];
    int          m_last;
    int          win;
    apply_reset();
    m_last = 1;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pwe[p] = 0; pa[p] = 0; pd[p] = 0; exp_rv[p] = 0; exp_rd[p] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] || $urandom_range(0, 15) == 0) begin
          pv[p]  = ($urandom_range(0, 3) != 0);
          pwe[p] = $urandom_range(0, 1) == 1;
          pa[p]  = 32'($urandom_range(0, 255));
          pd[p]  = $urandom;
        end
      end
      p0_valid = pv[0]; p0_we = pwe[0]; p0_addr = pa[0]; p0_wdata = pd[0];
      p1_valid = pv[1]; p1_we = pwe[1]; p1_addr = pa[1]; p1_wdata = pd[1];
      @(negedge clk);
      if (pv[0] && pv[1]) win = (m_last == 1) ? 0 : 1;
      else if (pv[0])     win = 0;
      else if (pv[1])     win = 1;
      else                win = -1;
      n_cmp++; if (p0_ready !== (win == 0) || p1_ready !== (win == 1)) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%0b%0b want winner=%0d", cyc, p0_ready, p1_ready, win); end
      n_cmp++; if (p0_rvalid !== exp_rv[0] || p1_rvalid !== exp_rv[1]) begin n_bad++; $display("FAIL rnd_rvalid cyc=%0d got=%0b%0b want=%0b%0b", cyc, p0_rvalid, p1_rvalid, exp_rv[0], exp_rv[1]); end
      n_cmp++; if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin n_bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h/%h", cyc, p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]); end
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (win >= 0) begin
        n_cmp++; if (mem_addr !== pa[win] || mem_wr_en !== pwe[win] || mem_rd_en !== !pwe[win]) begin n_bad++; $display("FAIL rnd_mem cyc=%0d got addr=%0d wr=%0b rd=%0b want %0d %0b", cyc, mem_addr, mem_wr_en, mem_rd_en, pa[win], pwe[win]); end
        if (pwe[win]) begin
          n_cmp++; if (mem_wdata !== pd[win]) begin n_bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, mem_wdata, pd[win]); end
          ref_mem[pa[win][7:0]] = pd[win];
        end else begin
          exp_rv[win] = 1;
          exp_rd[win] = ref_mem[pa[win][7:0]];
        end
        m_last  = win;
        pv[win] = 0;
      end else begin
        n_cmp++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL rnd_idle cyc=%0d got wr=%0b rd=%0b addr=%0d want 0 0 0", cyc, mem_wr_en, mem_rd_en, mem_addr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_clear();
    test_reset_mid_clear();
    test_reset_after_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
